// File: rtl/bpg_pkg.sv
// Shared definitions for the block pattern generator: default geometry,
// sequencer state encoding and the playback length legality check.
package bpg_pkg;

  localparam int BPG_ADDR_W = 10;
  localparam int BPG_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_DONE
  } bpg_state_e;

  // A pass must contain at least one word and cannot exceed the memory depth.
  function automatic logic length_ok(input int unsigned len, input int unsigned depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/bpg_pattern_ram.sv
// Pattern storage: one write port fed by the pipe-in loader and one
// synchronous read port with a single cycle of latency. Contents are never reset.
module bpg_pattern_ram
  import bpg_pkg::*;
#(
  parameter int ADDR_W = BPG_ADDR_W,
  parameter int DATA_W = BPG_DATA_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bpg_sequencer.sv
// Block pattern generator: loads words from a FrontPanel pipe into RAM and
// replays them at a programmable rate for a programmable number of passes.
module bpg_sequencer
  import bpg_pkg::*;
#(
  parameter int ADDR_W = BPG_ADDR_W,
  parameter int DATA_W = BPG_DATA_W
) (
  input  logic              ep_clk,
  input  logic              ep_reset_n,
  input  logic              pipe_write,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              trig_start,
  input  logic              trig_stop,
  input  logic              trig_clear,
  input  logic [ADDR_W:0]   cfg_length,
  input  logic [15:0]       cfg_repeat,
  input  logic [7:0]        cfg_divider,
  output logic [DATA_W-1:0] pattern_out,
  output logic              pattern_strobe,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   load_count,
  output logic [15:0]       pass_count,
  output logic [2:0]        err_flags
);

  localparam int unsigned   DEPTH = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  bpg_state_e        state;
  logic [ADDR_W:0]   sh_length;
  logic [15:0]       sh_repeat;
  logic [7:0]        sh_divider;
  logic [7:0]        div_cnt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ram_we;
  logic              load_full;
  logic              start_ok;
  logic              start_go;
  logic              run_complete;
  logic              emit;
  logic              last_word;

  // The RAM is addressed with the pointer's next value so that rd_data
  // always holds the word at rd_ptr, ready to emit without a bubble.
  always_comb begin
    load_full    = (load_count == FULL);
    ram_we       = (state == ST_IDLE) && pipe_write && !trig_clear && !load_full;
    start_ok     = length_ok(32'(cfg_length), DEPTH);
    start_go     = (state == ST_IDLE) && trig_start && !trig_stop && start_ok;
    run_complete = (sh_repeat != 16'd0) && (pass_count == sh_repeat);
    emit         = (state == ST_RUN) && !trig_stop && !run_complete && (div_cnt == 8'd0);
    last_word    = ({1'b0, rd_ptr} == (sh_length - (ADDR_W+1)'(1)));
    ptr_next     = last_word ? '0 : rd_ptr + ADDR_W'(1);
    rd_addr      = rd_ptr;
    if (start_go) begin
      rd_addr = '0;
    end else if (emit) begin
      rd_addr = ptr_next;
    end
  end

  bpg_pattern_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (ep_clk),
    .wr_en   (ram_we),
    .wr_addr (load_count[ADDR_W-1:0]),
    .wr_data (pipe_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge ep_clk or negedge ep_reset_n) begin
    if (!ep_reset_n) begin
      state          <= ST_IDLE;
      pattern_out    <= '0;
      pattern_strobe <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      load_count     <= '0;
      pass_count     <= '0;
      err_flags      <= '0;
      sh_length      <= '0;
      sh_repeat      <= '0;
      sh_divider     <= '0;
      div_cnt        <= '0;
      rd_ptr         <= '0;
    end else begin
      pattern_strobe <= 1'b0;
      done           <= 1'b0;
      if (pipe_write && (state != ST_IDLE)) begin
        err_flags[1] <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (trig_clear) begin
            load_count <= '0;
            err_flags  <= '0;
          end else begin
            if (pipe_write) begin
              if (load_full) begin
                err_flags[0] <= 1'b1;
              end else begin
                load_count <= load_count + (ADDR_W+1)'(1);
              end
            end
            if (trig_start && !trig_stop && !start_ok) begin
              err_flags[2] <= 1'b1;
            end
          end
          if (start_go) begin
            sh_length  <= cfg_length;
            sh_repeat  <= cfg_repeat;
            sh_divider <= cfg_divider;
            pass_count <= '0;
            div_cnt    <= '0;
            rd_ptr     <= '0;
            busy       <= 1'b1;
            state      <= ST_PRIME;
          end
        end

        ST_PRIME: begin
          if (trig_stop) begin
            busy        <= 1'b0;
            pattern_out <= '0;
            state       <= ST_IDLE;
          end else begin
            state <= ST_RUN;
          end
        end

        // Completion is detected one cycle after the final word so the last
        // word keeps its full strobe slot before done is raised.
        ST_RUN: begin
          if (trig_stop) begin
            busy        <= 1'b0;
            pattern_out <= '0;
            state       <= ST_IDLE;
          end else if (run_complete) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (div_cnt == 8'd0) begin
            pattern_out    <= rd_data;
            pattern_strobe <= 1'b1;
            div_cnt        <= sh_divider;
            rd_ptr         <= ptr_next;
            if (last_word && (pass_count != 16'hFFFF)) begin
              pass_count <= pass_count + 16'd1;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        ST_DONE: begin
          pattern_out <= '0;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpg_sequencer.sv
// Directed scoreboard bench for bpg_sequencer: expected words are queued as
// each run is started and popped as strobes appear.
module tb_bpg_sequencer;

  logic        ep_clk;
  logic        ep_reset_n;
  logic        pipe_write;
  logic [15:0] pipe_data;
  logic        trig_start;
  logic        trig_stop;
  logic        trig_clear;
  logic [10:0] cfg_length;
  logic [15:0] cfg_repeat;
  logic [7:0]  cfg_divider;
  logic [15:0] pattern_out;
  logic        pattern_strobe;
  logic        busy;
  logic        done;
  logic [10:0] load_count;
  logic [15:0] pass_count;
  logic [2:0]  err_flags;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  logic [15:0] exp_q[$];
  int          strobe_cyc[$];

  bpg_sequencer dut (
    .ep_clk         (ep_clk),
    .ep_reset_n     (ep_reset_n),
    .pipe_write     (pipe_write),
    .pipe_data      (pipe_data),
    .trig_start     (trig_start),
    .trig_stop      (trig_stop),
    .trig_clear     (trig_clear),
    .cfg_length     (cfg_length),
    .cfg_repeat     (cfg_repeat),
    .cfg_divider    (cfg_divider),
    .pattern_out    (pattern_out),
    .pattern_strobe (pattern_strobe),
    .busy           (busy),
    .done           (done),
    .load_count     (load_count),
    .pass_count     (pass_count),
    .err_flags      (err_flags)
  );

  initial ep_clk = 1'b0;
  always #5 ep_clk = ~ep_clk;

  always @(posedge ep_clk) cycle <= cycle + 1;

  // Scoreboard: every strobe must match the oldest queued word.
  always @(negedge ep_clk) begin
    logic        sb_has;
    logic [15:0] exp_word;
    if (ep_reset_n === 1'b1 && pattern_strobe === 1'b1) begin
      sb_has = (exp_q.size() != 0);
      checks++;
      assert (sb_has === 1'b1) else begin
        errors++;
        $error("[TB] FAIL sb_extra_strobe: observed word 0x%0h with empty queue, expected no strobe", pattern_out);
      end
      if (sb_has) begin
        exp_word = exp_q.pop_front();
        checks++;
        assert (pattern_out === exp_word) else begin
          errors++;
          $error("[TB] FAIL sb_word: observed 0x%0h expected 0x%0h", pattern_out, exp_word);
        end
      end
      strobe_cyc.push_back(cycle);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [15:0] data,
                                input logic start, input logic stop, input logic clear);
    pipe_write = wr;
    pipe_data  = data;
    trig_start = start;
    trig_stop  = stop;
    trig_clear = clear;
    @(posedge ep_clk);
    #1;
    pipe_write = 1'b0;
    trig_start = 1'b0;
    trig_stop  = 1'b0;
    trig_clear = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge ep_clk);
    #1;
  endtask

  task automatic wait_done(input int max_cycles, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge ep_clk);
      #1;
      if (done === 1'b1) begin
        done_cyc = cycle;
        break;
      end
    end
  endtask

  task automatic wait_strobes(input int n, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge ep_clk);
      #1;
      if (strobe_cyc.size() >= n) break;
    end
    check_output("strobe_wait", strobe_cyc.size(), n);
  endtask

  function automatic int strobe_at(input int idx);
    return (strobe_cyc.size() > idx) ? strobe_cyc[idx] : -1;
  endfunction

  initial begin
    int t_start;
    int done_cyc;
    logic done_seen;

    ep_reset_n  = 1'b0;
    pipe_write  = 1'b0;
    pipe_data   = '0;
    trig_start  = 1'b0;
    trig_stop   = 1'b0;
    trig_clear  = 1'b0;
    cfg_length  = '0;
    cfg_repeat  = '0;
    cfg_divider = '0;
    repeat (3) @(posedge ep_clk);
    #1;
    check_output("rst_pattern_out", pattern_out, 0);
    check_output("rst_strobe", pattern_strobe, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_load_count", load_count, 0);
    check_output("rst_pass_count", pass_count, 0);
    check_output("rst_err_flags", err_flags, 0);
    ep_reset_n = 1'b1;
    idle_cycles(1);

    // Four words, two passes, no divider gaps
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 16'(16'h1111 * (i + 1)), 1'b0, 1'b0, 1'b0);
    check_output("load4_count", load_count, 4);
    check_output("load4_err", err_flags, 0);
    cfg_length = 11'd4; cfg_repeat = 16'd2; cfg_divider = 8'd0;
    strobe_cyc.delete();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) exp_q.push_back(16'(16'h1111 * (i + 1)));
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    t_start = cycle;
    check_output("prime_busy", busy, 1);
    wait_done(40, done_cyc);
    check_output("r1_done_cycle", done_cyc, t_start + 10);
    check_output("r1_strobes", strobe_cyc.size(), 8);
    check_output("r1_first_latency", strobe_at(0), t_start + 2);
    check_output("r1_last_strobe", strobe_at(7), t_start + 9);
    check_output("r1_pass_count", pass_count, 2);
    check_output("r1_sb_drain", exp_q.size(), 0);
    @(negedge ep_clk); #1;
    check_output("r1_done_pulse", done, 0);
    check_output("r1_idle_out", pattern_out, 0);
    check_output("r1_idle_busy", busy, 0);

    // Divider 3: strobes four cycles apart
    cfg_length = 11'd2; cfg_repeat = 16'd1; cfg_divider = 8'd3;
    strobe_cyc.delete();
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    t_start = cycle;
    wait_done(40, done_cyc);
    check_output("r2_done_cycle", done_cyc, t_start + 7);
    check_output("r2_first", strobe_at(0), t_start + 2);
    check_output("r2_second", strobe_at(1), t_start + 6);
    check_output("r2_pass_count", pass_count, 1);
    @(negedge ep_clk); #1;
    check_output("r2_out_zero", pattern_out, 0);
    check_output("r2_sb_drain", exp_q.size(), 0);

    // Infinite repeat, stopped after ten strobes
    cfg_length = 11'd2; cfg_repeat = 16'd0; cfg_divider = 8'd0;
    strobe_cyc.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 2 == 0) ? 16'h1111 : 16'h2222);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    wait_strobes(10, 40);
    trig_stop = 1'b1;
    @(posedge ep_clk); #1;
    trig_stop = 1'b0;
    check_output("r3_busy_after_stop", busy, 0);
    check_output("r3_out_after_stop", pattern_out, 0);
    done_seen = done;
    for (int i = 0; i < 4; i++) begin
      @(negedge ep_clk); #1;
      done_seen = done_seen | done;
    end
    check_output("r3_no_done", done_seen, 0);
    check_output("r3_pass_count", pass_count, 5);
    check_output("r3_strobes", strobe_cyc.size(), 10);

    // Overfill the memory by one word, then clear
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_output("clr_load_count", load_count, 0);
    for (int i = 0; i < 1025; i++) apply_stimulus(1'b1, 16'(i) ^ 16'hA5A5, 1'b0, 1'b0, 1'b0);
    check_output("full_load_count", load_count, 1024);
    check_output("full_err", err_flags, 3'b001);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_output("full_clr_count", load_count, 0);
    check_output("full_clr_err", err_flags, 0);

    // Illegal lengths and simultaneous start/stop
    strobe_cyc.delete();
    cfg_length = 11'd0; cfg_repeat = 16'd1; cfg_divider = 8'd0;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle_cycles(2);
    check_output("len0_busy", busy, 0);
    check_output("len0_err", err_flags, 3'b100);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_output("len0_clr_err", err_flags, 0);
    cfg_length = 11'd1025;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle_cycles(2);
    check_output("len1025_busy", busy, 0);
    check_output("len1025_err", err_flags, 3'b100);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cfg_length = 11'd4;
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle_cycles(3);
    check_output("startstop_busy", busy, 0);
    check_output("startstop_err", err_flags, 0);
    check_output("startstop_strobes", strobe_cyc.size(), 0);

    // Load while busy, then asynchronous reset mid-run
    cfg_length = 11'd4; cfg_repeat = 16'd0; cfg_divider = 8'd1;
    strobe_cyc.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(16'(i % 4) ^ 16'hA5A5);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    wait_strobes(3, 40);
    pipe_write = 1'b1; pipe_data = 16'hDEAD;
    @(posedge ep_clk); #1;
    pipe_write = 1'b0;
    check_output("busy_load_err", err_flags, 3'b010);
    check_output("busy_load_count", load_count, 0);
    check_output("pre_reset_out", pattern_out, 16'hA5A7);
    #1;
    ep_reset_n = 1'b0;
    #1;
    check_output("async_rst_out", pattern_out, 0);
    check_output("async_rst_busy", busy, 0);
    check_output("async_rst_strobe", pattern_strobe, 0);
    exp_q.delete();
    repeat (2) @(posedge ep_clk);
    #1;
    check_output("rst_err_clear", err_flags, 0);
    check_output("rst_pass_clear", pass_count, 0);
    ep_reset_n = 1'b1;
    idle_cycles(1);

    // Memory survives reset
    cfg_length = 11'd4; cfg_repeat = 16'd1; cfg_divider = 8'd0;
    strobe_cyc.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i) ^ 16'hA5A5);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    t_start = cycle;
    wait_done(30, done_cyc);
    check_output("r4_done_cycle", done_cyc, t_start + 6);
    check_output("r4_strobes", strobe_cyc.size(), 4);
    check_output("r4_pass_count", pass_count, 1);
    check_output("r4_sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
